// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed program into instruction memory, then releases the CPU.
// Latency: one write strobe the cycle after the LOW byte is taken; best case 1 instruction / 3 cycles.
// Backpressure: byteReady is registered from the next state; low in WRITE/DONE and the first cycle after reset.
//
// Ports:
//   clock, isReset          - rising-edge clock, synchronous active-low reset
//   byteIn/byteValid/Ready  - valid/ready byte stream: LEN, N x {HIGH, LOW}, [CHK]
//   memWriteEnable/Address/WriteData - single-cycle instruction-memory write port
//   cpuHold, loadDone, loadError     - CPU reset hold and load status
// Optional feature: define CHECKSUM_EN to add a trailing XOR checksum byte and loadError reporting.
module program_loader #(
  parameter int PC_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         isReset,
  input  logic [7:0]                   byteIn,
  input  logic                         byteValid,
  output logic                         byteReady,
  output logic                         memWriteEnable,
  output logic [PC_WIDTH-1:0]          memAddress,
  output logic [INSTRUCTION_WIDTH-1:0] memWriteData,
  output logic                         cpuHold,
  output logic                         loadDone,
  output logic                         loadError
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_WRITE,
`ifdef CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  // State entered once the last instruction word (or an empty LEN) has been handled.
`ifdef CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t                       state_q, state_d;
  logic [7:0]                   count_q, count_d;
  logic [PC_WIDTH-1:0]          addr_q, addr_d;
  logic [INSTRUCTION_WIDTH-1:0] data_q, data_d;
  logic                         ready_q, ready_d;
  logic                         we_q, we_d;
  logic                         hold_q, hold_d;
  logic                         done_q, done_d;
  logic                         fire;
`ifdef CHECKSUM_EN
  logic [7:0]                   csum_q, csum_d;
  logic                         err_q, err_d;
`endif

  assign fire = byteValid && ready_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          count_d = byteIn;
`ifdef CHECKSUM_EN
          csum_d  = byteIn;
`endif
          state_d = (byteIn != 8'd0) ? S_HIGH : S_END;
        end
      end
      S_HIGH: begin
        if (fire) begin
          data_d  = {byteIn, data_q[7:0]};
`ifdef CHECKSUM_EN
          csum_d  = csum_q ^ byteIn;
`endif
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (fire) begin
          data_d  = {data_q[INSTRUCTION_WIDTH-1:8], byteIn};
`ifdef CHECKSUM_EN
          csum_d  = csum_q ^ byteIn;
`endif
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The strobe is visible this cycle with the current address; advance afterwards.
        addr_d  = addr_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        count_d = count_q - 8'd1;
        state_d = (count_q == 8'd1) ? S_END : S_HIGH;
      end
`ifdef CHECKSUM_EN
      S_CHECK: begin
        if (fire) begin
          err_d   = (byteIn != csum_q);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Stream-facing and memory-facing outputs are registered from the next state so they
    // line up with state_q and are glitch-free.
    ready_d = (state_d == S_IDLE) || (state_d == S_HIGH) || (state_d == S_LOW)
`ifdef CHECKSUM_EN
              || (state_d == S_CHECK)
`endif
              ;
    we_d    = (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    // CPU release trails DONE by one cycle; a checksum failure keeps the CPU held.
`ifdef CHECKSUM_EN
    hold_d  = !((state_q == S_DONE) && !err_q);
`else
    hold_d  = (state_q != S_DONE);
`endif
  end

  always_ff @(posedge clock) begin
    if (!isReset) begin
      state_q <= S_IDLE;
      count_q <= 8'd0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q  <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign byteReady      = ready_q;
  assign memWriteEnable = we_q;
  assign memAddress     = addr_q;
  assign memWriteData   = data_q;
  assign cpuHold        = hold_q;
  assign loadDone       = done_q;
`ifdef CHECKSUM_EN
  assign loadError      = err_q;
`else
  assign loadError      = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clock = 1'b0;
  logic        isReset;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        memWriteEnable;
  logic [7:0]  memAddress;
  logic [15:0] memWriteData;
  logic        cpuHold;
  logic        loadDone;
  logic        loadError;

  always #5 clock = ~clock;

  program_loader #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(16)) dut (
    .clock(clock), .isReset(isReset), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .memWriteEnable(memWriteEnable), .memAddress(memAddress),
    .memWriteData(memWriteData), .cpuHold(cpuHold), .loadDone(loadDone), .loadError(loadError)
  );

  typedef struct {
    logic [7:0]  n;
    logic [15:0] w0;
    logic [15:0] w1;
    bit          gaps;
    logic [7:0]  exp_addr;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];          // {address, data} of each expected write
  logic [15:0] mem_model[256];    // instruction memory as seen through the write port
  logic        prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the next expected write and last one cycle.
  always @(negedge clock) begin
    if (memWriteEnable === 1'b1) begin
      mem_model[memAddress] = memWriteData;
      check("strobe_ready_low", {31'd0, byteReady}, 32'd0);
      check("strobe_width", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got %0h@%0h expected none", memWriteData, memAddress);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("write", {8'd0, memAddress, memWriteData}, {8'd0, e});
      end
    end
    prev_we = memWriteEnable;
  end

  // All tasks are entered and left just after a falling edge.
  task automatic do_reset();
    isReset   = 1'b0;
    byteValid = 1'b0;
    byteIn    = 8'h00;
    @(negedge clock);
    check("rst_ready", {31'd0, byteReady}, 32'd0);
    check("rst_we", {31'd0, memWriteEnable}, 32'd0);
    check("rst_addr", {24'd0, memAddress}, 32'd0);
    check("rst_data", {16'd0, memWriteData}, 32'd0);
    check("rst_hold", {31'd0, cpuHold}, 32'd1);
    check("rst_done", {31'd0, loadDone}, 32'd0);
    check("rst_error", {31'd0, loadError}, 32'd0);
    exp_q.delete();
    isReset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", {31'd0, byteReady}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    byteIn    = b;
    byteValid = 1'b1;
    while (byteReady !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: byte %0h never accepted, byteReady=%b", b, byteReady);
    end
    @(negedge clock);
    byteValid = 1'b0;
    if (gaps) @(negedge clock);
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    send_byte(w[15:8], gaps);
    exp_q.push_back({memAddress, w});
    send_byte(w[7:0], gaps);
  endtask

  task automatic wait_done();
    int t = 0;
    while (loadDone !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("load_done", {31'd0, loadDone}, 32'd1);
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic check_no_more_bytes();
    byteIn    = 8'h55;
    byteValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("done_ready_low", {31'd0, byteReady}, 32'd0);
    end
    byteValid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] chk;
    chk = v.n;
    send_byte(v.n, v.gaps);
    if (v.n >= 8'd1) begin
      send_word(v.w0, v.gaps);
      chk = chk ^ v.w0[15:8] ^ v.w0[7:0];
    end
    if (v.n >= 8'd2) begin
      send_word(v.w1, v.gaps);
      chk = chk ^ v.w1[15:8] ^ v.w1[7:0];
    end
`ifdef CHECKSUM_EN
    send_byte(chk, v.gaps);
`endif
    wait_done();
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_addr", {24'd0, memAddress}, {24'd0, v.exp_addr});
    check("cpu_released", {31'd0, cpuHold}, 32'd0);
    check("no_error", {31'd0, loadError}, 32'd0);
    check_no_more_bytes();
  endtask

  initial begin
    vec_t vecs[4];
    vecs[0] = '{8'd2, 16'h1234, 16'hABCD, 1'b0, 8'd2};
    vecs[1] = '{8'd2, 16'h1234, 16'hABCD, 1'b1, 8'd2};
    vecs[2] = '{8'd0, 16'h0000, 16'h0000, 1'b0, 8'd0};
    vecs[3] = '{8'd1, 16'hBEEF, 16'h0000, 1'b1, 8'd1};

    isReset   = 1'b0;
    byteValid = 1'b0;
    byteIn    = 8'h00;
    @(negedge clock);

    for (int k = 0; k < 4; k++) begin
      do_reset();
      run_frame(vecs[k]);
    end

    // Reset in the middle of a load, then a fresh frame must start at address 0.
    do_reset();
    send_byte(8'h02, 1'b0);
    send_word(16'h1234, 1'b0);
    send_byte(8'hAB, 1'b0);
    do_reset();
    run_frame('{8'd1, 16'h5678, 16'h0000, 1'b0, 8'd1});

`ifdef CHECKSUM_EN
    // Good and bad checksum for frame 01,12,34,CHK.
    for (int bad = 0; bad < 2; bad++) begin
      logic [7:0] chk;
      chk = 8'h01 ^ 8'h12 ^ 8'h34;
      if (bad == 1) chk = chk ^ 8'h01;
      do_reset();
      send_byte(8'h01, 1'b0);
      send_word(16'h1234, 1'b0);
      send_byte(chk, 1'b0);
      wait_done();
      check("chk_error", {31'd0, loadError}, {31'd0, bad[0]});
      check("chk_hold", {31'd0, cpuHold}, {31'd0, bad[0]});
    end
`endif

    // Full 255-word program with data {i, ~i}.
    do_reset();
    begin
      logic [7:0] chk;
      logic [7:0] iv;
      chk = 8'hFF;
      send_byte(8'hFF, 1'b0);
      for (int i = 0; i < 255; i++) begin
        iv = i[7:0];
        send_word({iv, ~iv}, 1'b0);
        chk = chk ^ iv ^ ~iv;
      end
`ifdef CHECKSUM_EN
      send_byte(chk, 1'b0);
`endif
    end
    wait_done();
    check("full_queue_drained", exp_q.size(), 32'd0);
    check("full_final_addr", {24'd0, memAddress}, 32'hFF);
    check("full_cpu_released", {31'd0, cpuHold}, 32'd0);
    for (int i = 0; i < 255; i++) begin
      logic [7:0] iv;
      iv = i[7:0];
      check("readback", {16'd0, mem_model[i]}, {16'd0, iv, ~iv});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
